// File: rtl/uart_mmio_fifo_if.sv
// CPU register bus and UART character handshakes for uart_mmio_fifo.
// The slave modport is the buffer block. The master modport is the CPU/UART side that drives it.
interface uart_mmio_fifo_if #(
  parameter int DATA_W = 8
);
  logic              stall;
  logic [1:0]        cpu_addr;
  logic              cpu_re;
  logic              cpu_we;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic [DATA_W-1:0] uart_rx_data;
  logic              uart_rx_valid;
  logic              uart_rx_ready;
  logic [DATA_W-1:0] uart_tx_data;
  logic              uart_tx_valid;
  logic              uart_tx_ready;

  modport slave (
    input  stall, cpu_addr, cpu_re, cpu_we, cpu_wdata,
    output cpu_rdata,
    input  uart_rx_data, uart_rx_valid,
    output uart_rx_ready,
    output uart_tx_data, uart_tx_valid,
    input  uart_tx_ready
  );

  modport master (
    output stall, cpu_addr, cpu_re, cpu_we, cpu_wdata,
    input  cpu_rdata,
    output uart_rx_data, uart_rx_valid,
    input  uart_rx_ready,
    input  uart_tx_data, uart_tx_valid,
    output uart_tx_ready
  );
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART buffer: RX and TX circular FIFOs behind the STATUS, RXDATA, TXDATA and CTRL registers.
// Sticky flags record RX overflow, TX overflow and RX underflow until software clears them.
module uart_mmio_fifo #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_mmio_fifo_if.slave     bus
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_RXDATA = 2'd1,
    REG_TXDATA = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
  logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW:0]    rx_count;
  logic [TX_AW:0]    tx_count;
  logic              rx_ovf, tx_ovf, rx_udf;
  logic              rx_ready_q;
  logic [31:0]       rdata_q;

  reg_e addr;
  logic cpu_rd, cpu_wr, ctrl_wr;
  logic rx_flush, tx_flush, flag_clr;
  logic rx_full, rx_empty, tx_full;
  logic rx_pop_req, rx_pop, rx_push, rx_ovf_set, rx_udf_set;
  logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
  logic [DATA_W-1:0] rx_head;
  logic [31:0] status;
  logic unused_wdata;

  assign addr     = reg_e'(bus.cpu_addr);
  assign cpu_rd   = bus.cpu_re & ~bus.stall;
  assign cpu_wr   = bus.cpu_we & ~bus.stall;
  assign ctrl_wr  = cpu_wr && addr == REG_CTRL;
  assign rx_flush = ctrl_wr & bus.cpu_wdata[0];
  assign tx_flush = ctrl_wr & bus.cpu_wdata[1];
  assign flag_clr = ctrl_wr & bus.cpu_wdata[2];
  assign unused_wdata = ^bus.cpu_wdata;

  assign rx_full  = rx_count == RX_FULL_CNT;
  assign rx_empty = rx_count == '0;
  assign tx_full  = tx_count == TX_FULL_CNT;
  assign rx_head  = rx_mem[rx_rd_ptr];

  // A pop from a full FIFO frees the slot that a push in the same cycle needs, so both go ahead.
  assign rx_pop_req = cpu_rd && addr == REG_RXDATA;
  assign rx_pop     = rx_pop_req & ~rx_empty & ~rx_flush;
  assign rx_push    = bus.uart_rx_valid & (~rx_full | rx_pop) & ~rx_flush;
  assign rx_ovf_set = bus.uart_rx_valid & rx_full & ~rx_pop & ~rx_flush;
  assign rx_udf_set = rx_pop_req & rx_empty;

  assign tx_pop      = bus.uart_tx_valid & bus.uart_tx_ready & ~tx_flush;
  assign tx_push_req = cpu_wr && addr == REG_TXDATA;
  assign tx_push     = tx_push_req & (~tx_full | tx_pop) & ~tx_flush;
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop & ~tx_flush;

  assign status = {8'h00, 8'(tx_count), 8'(rx_count),
                   3'b000, rx_udf, tx_ovf, rx_ovf, ~tx_full, ~rx_empty};

  assign bus.cpu_rdata     = rdata_q;
  assign bus.uart_rx_ready = rx_ready_q;
  assign bus.uart_tx_valid = tx_count != '0;
  assign bus.uart_tx_data  = tx_mem[tx_rd_ptr];

  // NOTE: storage arrays carry no reset; the pointers and counts define which entries are valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.uart_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.cpu_wdata[DATA_W-1:0];
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      rx_ovf     <= 1'b0;
      tx_ovf     <= 1'b0;
      rx_udf     <= 1'b0;
      rx_ready_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rx_ready_q <= 1'b1;

      if (rx_flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_count  <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
        case ({rx_push, rx_pop})
          2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
          2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
          default: rx_count <= rx_count;
        endcase
      end

      if (tx_flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_count  <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
        case ({tx_push, tx_pop})
          2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
          2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
          default: tx_count <= tx_count;
        endcase
      end

      if (flag_clr) begin
        rx_ovf <= 1'b0;
        tx_ovf <= 1'b0;
        rx_udf <= 1'b0;
      end else begin
        rx_ovf <= rx_ovf | rx_ovf_set;
        tx_ovf <= tx_ovf | tx_ovf_set;
        rx_udf <= rx_udf | rx_udf_set;
      end

      if (cpu_rd) begin
        case (addr)
          REG_STATUS: rdata_q <= status;
          REG_RXDATA: rdata_q <= rx_empty ? 32'h0 : 32'(rx_head);
          default:    rdata_q <= 32'h0;
        endcase
      end
    end
  end
endmodule
